// File: rtl/mac_if_pkg.sv
// mac_if_pkg: shared state type, default sizing and counter helper for the rx frame buffer
package mac_if_pkg;
  localparam int RX_BUF_DEPTH = 2048;
  localparam int RX_BUF_DECISION_CYCLES = 4;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DECIDE,
    ST_DISCARD
  } rx_buf_state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram: one write port, one registered read port, no reset on contents
module simple_dual_port_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: stores MAC frames speculatively, releases them only once judged good
module rx_frame_buffer
  import mac_if_pkg::*;
#(
  parameter int DEPTH = RX_BUF_DEPTH,
  parameter int DECISION_CYCLES = RX_BUF_DECISION_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        invalid_frame_i,
  output logic [7:0]  m_data_o,
  output logic        m_valid_o,
  output logic        m_last_o,
  input  logic        m_ready_i,
  output logic [15:0] frames_ok_o,
  output logic [15:0] frames_dropped_o,
  output logic        overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [3:0] LAST_CNT = 4'(DECISION_CYCLES - 1);

  rx_buf_state_t state_q, state_d;
  logic [7:0]    pend_q, pend_d;
  logic          err_q, err_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] fill;
  logic          rx_prev_q;
  logic          ovf_q, ovf_d;
  logic [15:0]   ok_q, drop_q;
  logic          ok_inc, drop_inc;
  logic          we, wlast, space, bad, issue, out_v_q;
  logic [8:0]    rd_data;

  assign fill  = wr_ptr_q - rd_ptr_q;
  assign space = fill < DEPTH_P;
  assign bad   = invalid_frame_i | err_q;
  assign issue = (rd_ptr_q != commit_ptr_q) && (!out_v_q || m_ready_i);

  simple_dual_port_ram #(
    .WIDTH(9),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(wr_ptr_q[AW-1:0]),
    .wdata_i({wlast, pend_q}),
    .re_i   (issue),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(rd_data)
  );

  // receive FSM: pending-byte write, sticky error, post-frame decision window, overflow discard
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    we           = 1'b0;
    wlast        = 1'b0;
    ok_inc       = 1'b0;
    drop_inc     = 1'b0;
    ovf_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i && !rx_prev_q) begin
          state_d = ST_RECV;
          pend_d  = rx_data_i;
          err_d   = invalid_frame_i;
        end
      end
      ST_RECV: begin
        err_d = err_q | invalid_frame_i;
        if (!space) begin
          wr_ptr_d = commit_ptr_q;
          ovf_d    = 1'b1;
          drop_inc = 1'b1;
          state_d  = rx_valid_i ? ST_DISCARD : ST_IDLE;
        end else begin
          we       = 1'b1;
          wlast    = !rx_valid_i;
          wr_ptr_d = wr_ptr_q + PW'(1);
          pend_d   = rx_valid_i ? rx_data_i : pend_q;
          state_d  = rx_valid_i ? ST_RECV : ST_DECIDE;
          cnt_d    = '0;
        end
      end
      ST_DECIDE: begin
        if (rx_valid_i || bad || cnt_q == LAST_CNT) begin
          wr_ptr_d     = bad ? commit_ptr_q : wr_ptr_q;
          commit_ptr_d = bad ? commit_ptr_q : wr_ptr_q;
          drop_inc     = bad;
          ok_inc       = !bad;
          state_d      = rx_valid_i ? ST_RECV : ST_IDLE;
          pend_d       = rx_valid_i ? rx_data_i : pend_q;
          err_d        = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DISCARD: state_d = rx_valid_i ? ST_DISCARD : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // write-side registers; rx_prev resets high so a frame in flight at reset release is skipped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rx_prev_q    <= 1'b1;
      ovf_q        <= 1'b0;
      ok_q         <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rx_prev_q    <= rx_valid_i;
      ovf_q        <= ovf_d;
      ok_q         <= sat_inc(ok_q, ok_inc);
      drop_q       <= sat_inc(drop_q, drop_inc);
    end
  end

  // read side: the RAM read register doubles as the output stage, refilled on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      out_v_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(issue);
      out_v_q  <= issue | (out_v_q & ~m_ready_i);
    end
  end

  assign m_valid_o        = out_v_q;
  assign m_data_o         = out_v_q ? rd_data[7:0] : 8'h00;
  assign m_last_o         = out_v_q & rd_data[8];
  assign overflow_o       = ovf_q;
  assign frames_ok_o      = ok_q;
  assign frames_dropped_o = drop_q;
endmodule

// File: tb/tb_rx_frame_buffer.sv
// tb_rx_frame_buffer: directed and random frames against a frame-level reference model
module tb_rx_frame_buffer;
  localparam int DEPTH = 2048;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        invalid_frame_i = 1'b0;
  logic        m_ready_i = 1'b1;
  logic [7:0]  m_data_o;
  logic        m_valid_o, m_last_o, overflow_o;
  logic [15:0] frames_ok_o, frames_dropped_o;

  int n_cmp = 0, n_bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] prev_q[$];
  bit prev_open = 0, prev_bad = 0;
  int ok_exp = 0, drop_exp = 0, ovf_exp = 0, ovf_seen = 0, xfer_cnt = 0, rmode = 1;
  bit hold_v = 0;
  logic [8:0] hold_b;

  rx_frame_buffer dut (
    .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .invalid_frame_i(invalid_frame_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_last_o(m_last_o), .m_ready_i(m_ready_i), .frames_ok_o(frames_ok_o),
    .frames_dropped_o(frames_dropped_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // output monitor: every accepted byte against the model queue, plus hold-stability under backpressure
  always @(negedge clk) begin
    if (!rst_n) hold_v = 0;
    else begin
      if (hold_v) check("hold_stable", {22'd0, m_valid_o, m_last_o, m_data_o}, {22'd0, 1'b1, hold_b});
      if (m_valid_o && m_ready_i) begin
        check("out_byte", {22'd0, 1'b0, m_last_o, m_data_o},
              exp_q.size() != 0 ? {22'd0, 1'b0, exp_q[0]} : 32'h3FF);
        if (exp_q.size() != 0) exp_q.delete(0);
        xfer_cnt++;
      end
      if (overflow_o) ovf_seen++;
      hold_v = m_valid_o && !m_ready_i;
      hold_b = {m_last_o, m_data_o};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_ready_i = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
  endtask

  task automatic resolve();
    if (prev_open) begin
      if (prev_bad) drop_exp++;
      else begin
        foreach (prev_q[i]) exp_q.push_back(prev_q[i]);
        ok_exp++;
      end
      prev_open = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    prev_q.delete();
    prev_open = 0;
    ok_exp = 0;
    drop_exp = 0;
    ovf_exp = 0;
    ovf_seen = 0;
  endtask

  // frame of len bytes, optional invalid pulse at cycle inv_at counted from frame start, then gap idle cycles
  task automatic send_frame(input int len, input int inv_at, input int gap);
    logic [8:0] cur[$];
    bit take_prev, bad, ovf;
    int ram;
    take_prev = prev_open && inv_at == 0;
    if (take_prev) prev_bad = 1;
    ram = exp_q.size() + (prev_open ? prev_q.size() : 0) - (exp_q.size() > 0 ? 1 : 0);
    resolve();
    ovf = ram + len > DEPTH;
    bad = !take_prev && inv_at >= 0 && inv_at <= len + DC && inv_at < len + gap;
    for (int i = 0; i < len; i++) cur.push_back({i == len - 1, 8'($urandom)});
    if (ovf) begin
      drop_exp++;
      ovf_exp++;
    end else if (gap > DC) begin
      if (bad) drop_exp++;
      else begin
        foreach (cur[i]) exp_q.push_back(cur[i]);
        ok_exp++;
      end
    end else begin
      prev_q = cur;
      prev_open = 1;
      prev_bad = bad;
    end
    for (int i = 0; i < len + gap; i++) begin
      rx_valid_i = i < len;
      rx_data_i = i < len ? cur[i][7:0] : 8'h00;
      invalid_frame_i = i == inv_at;
      tick();
    end
    invalid_frame_i = 0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid_o) && n < bound) begin
      tick();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic check_counts();
    repeat (DC + 4) tick();
    check("frames_ok", {16'd0, frames_ok_o}, ok_exp);
    check("frames_dropped", {16'd0, frames_dropped_o}, drop_exp);
    check("overflow_pulses", ovf_seen, ovf_exp);
  endtask

  task automatic check_zero_outputs(input string tag);
    check(tag, {20'd0, m_valid_o, m_last_o, overflow_o, m_data_o, 1'b0}, 32'd0);
    check("counters_zero", {frames_ok_o, frames_dropped_o}, 32'd0);
  endtask

  initial begin
    int n, x0, len, gap, inv;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_outputs");
    rst_n = 1;
    tick();
    tick();

    x0 = xfer_cnt;
    send_frame(64, -1, 1);
    resolve();
    n = 0;
    while (!m_valid_o && n < 20) begin
      tick();
      n++;
    end
    check("valid_latency_ok", {31'd0, n <= DC + 2}, 1);
    for (int i = 0; i < 64; i++) begin
      check("burst_valid", {31'd0, m_valid_o}, 1);
      check("burst_last", {31'd0, m_last_o}, {31'd0, i == 63});
      tick();
    end
    check("valid_after_burst", {31'd0, m_valid_o}, 0);
    check("xfer_single", xfer_cnt - x0, 64);
    check_counts();

    x0 = xfer_cnt;
    send_frame(64, 66, 12);
    wait_drain(100);
    check("xfer_late_invalid", xfer_cnt - x0, 0);
    check_counts();

    x0 = xfer_cnt;
    send_frame(60, -1, 12);
    send_frame(100, 50, 12);
    send_frame(70, -1, 12);
    wait_drain(2000);
    check("xfer_abc", xfer_cnt - x0, 130);
    check_counts();

    x0 = xfer_cnt;
    send_frame(30, -1, 2);
    send_frame(30, -1, 12);
    wait_drain(500);
    check("xfer_early_start", xfer_cnt - x0, 60);
    check_counts();
    x0 = xfer_cnt;
    send_frame(30, -1, 2);
    send_frame(30, 0, 12);
    wait_drain(500);
    check("xfer_start_invalid", xfer_cnt - x0, 30);
    check_counts();

    rmode = 2;
    for (int k = 0; k < 24; k++) begin
      len = $urandom_range(1, 80);
      gap = $urandom_range(1, 8);
      inv = $urandom_range(0, 1) ? -1 : int'($urandom_range(0, len + DC + 2));
      send_frame(len, inv, gap);
    end
    resolve();
    wait_drain(20000);
    check_counts();

    rmode = 1;
    wait_drain(1000);
    rmode = 0;
    tick();
    x0 = xfer_cnt;
    send_frame(2040, -1, 12);
    repeat (4) tick();
    send_frame(20, -1, 12);
    check_counts();
    check("xfer_while_stalled", xfer_cnt - x0, 0);
    rmode = 1;
    wait_drain(5000);
    check("xfer_after_overflow", xfer_cnt - x0, 2040);
    check_counts();

    for (int i = 0; i < 10; i++) begin
      rx_valid_i = 1;
      rx_data_i = 8'($urandom);
      tick();
    end
    rst_n = 0;
    #1;
    check_zero_outputs("reset_mid_frame");
    model_reset();
    tick();
    tick();
    rst_n = 1;
    repeat (5) tick();
    rx_valid_i = 0;
    tick();
    x0 = xfer_cnt;
    send_frame(40, -1, 12);
    wait_drain(500);
    check("xfer_after_reset_frame", xfer_cnt - x0, 40);
    check_counts();

    x0 = xfer_cnt;
    send_frame(200, -1, 12);
    n = 0;
    while (xfer_cnt - x0 < 50 && n < 400) begin
      tick();
      n++;
    end
    rst_n = 0;
    #1;
    check_zero_outputs("reset_mid_drain");
    model_reset();
    tick();
    rst_n = 1;
    tick();
    x0 = xfer_cnt;
    send_frame(40, -1, 12);
    wait_drain(500);
    check("xfer_after_reset_drain", xfer_cnt - x0, 40);
    check_counts();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 Parameter DEPTH, default 2048, byte-buffer depth; power of two, at least 2048.
REQ-002 Parameter DECISION_CYCLES, default 4, cycles after frame end to wait for an invalid pulse; range 1..8.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 rx_data_i  in  8  frame byte from the receive MAC.
REQ-006 rx_valid_i  in  1  high for every byte of a frame, contiguous; falling edge marks frame end.
REQ-007 invalid_frame_i  in  1  one-cycle pulse: the current or just-ended frame is bad (FCS or parser error).
REQ-008 m_data_o  out  8  output byte.
REQ-009 m_valid_o  out  1  output byte valid.
REQ-010 m_last_o  out  1  last byte of a frame, qualified by m_valid_o.
REQ-011 m_ready_i  in  1  downstream accept; a transfer occurs when m_valid_o and m_ready_i are both high.
REQ-012 frames_ok_o  out  16  committed-frame count, saturating.
REQ-013 frames_dropped_o  out  16  dropped-frame count (invalid or overflow), saturating.
REQ-014 overflow_o  out  1  one-cycle pulse when a frame is dropped for lack of space.

Function
REQ-015 Storage SHALL be a circular RAM of DEPTH 9-bit entries {last, data}, with pointers rd_ptr, wr_ptr (speculative) and commit_ptr, each log2(DEPTH)+1 bits wide with wrap bit.
REQ-016 The FSM SHALL have the states IDLE, RECV, DECIDE and DISCARD.
REQ-017 Each incoming byte SHALL be held in a pending register and written to RAM when the next byte arrives; on the rx_valid_i falling edge the pending byte SHALL be written with last=1.
REQ-018 IDLE->RECV on rx_valid_i high; the first byte is loaded into the pending register.
REQ-019 In RECV, an invalid_frame_i pulse SHALL set a sticky err flag; at frame end the FSM SHALL go to DECIDE with its counter cleared.
REQ-020 In DECIDE, an invalid pulse or a set err flag SHALL restore wr_ptr to commit_ptr and increment frames_dropped_o; when the counter reaches DECISION_CYCLES with no pulse, commit_ptr SHALL take wr_ptr and frames_ok_o SHALL increment; both paths return to IDLE.
REQ-021 If rx_valid_i rises while in DECIDE, the frame SHALL resolve in that cycle: dropped if invalid_frame_i is high that cycle or err is set, otherwise committed. The FSM SHALL then enter RECV with the new byte captured.
REQ-022 A RAM write SHALL be allowed only when (wr_ptr - rd_ptr) < DEPTH; a byte with no space SHALL restore wr_ptr to commit_ptr, pulse overflow_o, increment frames_dropped_o and enter DISCARD.
REQ-023 DISCARD SHALL ignore bytes until rx_valid_i falls, then go to IDLE; an invalid pulse in DISCARD SHALL not count a second drop.
REQ-024 A frame SHALL only become readable once commit_ptr covers it; the read side SHALL never pass commit_ptr.
REQ-025 The read side SHALL use a one-entry output register: when the register is empty or being accepted and rd_ptr != commit_ptr, issue the RAM read and advance rd_ptr. The register is loaded on the next cycle.
REQ-026 m_valid_o SHALL assert within 2 cycles after a commit when the buffer was empty; with m_ready_i held high, throughput SHALL be 1 byte per cycle.
REQ-027 m_data_o and m_last_o SHALL hold stable while m_valid_o is high and m_ready_i is low.
REQ-028 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-029 When rst_n is low, all pointers, counters, err and the pending register SHALL clear, the FSM SHALL enter IDLE, and m_valid_o, m_last_o, overflow_o and m_data_o SHALL read 0.
REQ-030 A frame active when reset deasserts SHALL be ignored until rx_valid_i has been seen low.
REQ-031 RAM contents need no reset.

Structure
REQ-032 mac_if_pkg SHALL hold the FSM state enum rx_buf_state_t and the default constants RX_BUF_DEPTH and RX_BUF_DECISION_CYCLES.
REQ-033 The RAM SHALL be a sub-module simple_dual_port_ram: one write port, one registered read port, parameterised by width and depth.

Verification
REQ-034 One 64-byte frame with no invalid pulse, m_ready_i=1 -> 64 bytes out in order, m_last_o on byte 64 only, frames_ok_o=1.
REQ-035 Invalid pulse 2 cycles after a 64-byte frame ends -> no output, frames_dropped_o=1, commit_ptr unchanged.
REQ-036 Frames A (60 B, good), B (100 B, invalid pulse mid-frame), C (70 B, good), each separated by a 12-cycle gap -> A and C out back-to-back, 130 bytes total, frames_ok_o=2, frames_dropped_o=1.
REQ-037 m_ready_i=0 while 2040 bytes are committed, then a 20-byte frame arrives -> overflow_o pulses once, frames_dropped_o=1; after m_ready_i=1, exactly 2040 bytes drain.
REQ-038 DECISION_CYCLES=4, next frame starts 2 cycles after the previous frame ends -> first frame committed early and second frame intact; variant with invalid pulse in the start cycle -> first frame dropped.
REQ-039 rst_n asserted mid-frame and mid-drain -> all outputs 0 immediately; a subsequent good frame passes through intact.
